pov_pattern_engine: RTL and testbench
=====================================

Name: pov_pattern_engine

Overview:
Parametrised persistence-of-vision display engine for the LED fan.
- Tracks rotor angle from the per-step fan tick and re-aligns it on a once-per-revolution index sensor.
- Drives the LED column from a double-buffered, software-loadable pattern memory instead of hard-coded angle comparisons.
- Sits between the fan sensor inputs and the LED drivers; the host loads a new frame into the back bank and requests a swap, which takes effect only at a revolution boundary.

Parameters:
- LED_W, 16, number of LEDs in the column (bits per pattern word)
- STEPS, 360, angular positions per revolution
- ADDR_W, 9, angle/address width; must satisfy 2^ADDR_W >= STEPS
- STALL_CYCLES, 1000000, clk cycles without a fan tick before a stall is declared (used only with POV_STALL_DET_EN)

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset (synchronous, active-high); clock clk
- fanclk, in, 1, asynchronous angular step tick from the fan
- index, in, 1, asynchronous once-per-revolution sensor
- dir, in, 1, 0 = angle decrements per tick (legacy rotation sense), 1 = increments
- wr_en, in, 1, pattern write strobe
- wr_addr, in, ADDR_W, pattern angle address
- wr_data, in, LED_W, pattern word
- swap_req, in, 1, single-cycle request to swap banks at next revolution boundary
- err_clr, in, 1, clears sync_err
- led, out, LED_W, registered LED column output
- angle, out, ADDR_W, current angle, 0..STEPS-1
- rev_tick, out, 1, one-cycle pulse when angle becomes 0
- swap_pending, out, 1, swap armed, not yet taken
- sync_err, out, 1, sticky index-misalignment flag
- stalled, out, 1, fan stalled (0 when feature absent)

Behaviour:
- Reset values: angle=0, led=0, rev_tick=0, swap_pending=0, sync_err=0, stalled=0, front-bank select=0, blank=1. Memory contents are not reset.
- Input conditioning: fanclk and index each pass through a 2-flop synchronizer plus a rising-edge detector. Each yields one-cycle step and idx events. Synchronizer flops are cleared by rst.
- Angle update on a step event:
  - dir=1: angle+1; STEPS-1 wraps to 0.
  - dir=0: angle-1; 0 wraps to STEPS-1.
- idx event: angle is forced to 0 on the next edge. idx has priority over a simultaneous step.
- Sync check: if angle is neither 0 nor the wrap predecessor (STEPS-1 for dir=1, 1 for dir=0) when idx arrives, set sync_err.
  - sync_err holds until err_clr.
  - err_clr and a new error in the same cycle: set wins.
- Revolution boundary: any cycle in which angle transitions to 0 (natural wrap or idx). rev_tick pulses for 1 cycle, aligned with the new angle value. An idx arriving while angle is already 0 is not a boundary.
- Banks: two banks of STEPS x LED_W.
  - Writes go to the back bank, as defined at the start of the cycle.
  - wr_addr >= STEPS is ignored.
- Swap:
  - swap_req sets swap_pending.
  - At the next boundary, the bank select toggles, blank clears, and swap_pending clears.
  - swap_req coincident with a boundary is held pending for the following boundary.
  - Repeated swap_req while pending has no extra effect.
- LED output: led <= blank ? 0 : front[angle], registered. led reflects a new angle 1 cycle after angle updates. After a swap, the first led value read from the new front bank is the one for angle 0.
- Mid-operation reset: all state returns to reset values immediately. Memory contents are retained but blanked until the next swap.

Optional Feature:
- Macro: POV_STALL_DET_EN.
- With the macro defined:
  - A counter counts clk cycles since the last step event. It saturates at STALL_CYCLES.
  - At saturation, stalled=1 and led is forced to 0, so a stopped fan does not burn one column.
  - The next step event clears the counter and stalled. The led output resumes the following cycle.
  - Angle and banks are unaffected.
- Without the macro: no counter; stalled is tied to 0.

Test Plan:
- Reset, then 5 fanclk pulses with dir=0, no swap -> angle 0,359,358,357,356,355; led stays 0 (blank).
- Write pattern[k]=k for k=0..359, pulse swap_req, then drive ticks with dir=1 through a wrap -> swap taken at angle 0, rev_tick pulse, led=angle value one cycle after each angle change, swap_pending 1 then 0.
- Fan ticks with dir=1 to angle=100, then pulse index -> angle=0 and sync_err=1; err_clr -> 0. Index at angle 359 -> sync_err stays 0.
- fanclk and index rising edges in the same cycle, angle=50 -> angle=0, not 51.
- Write wr_addr=400 during operation -> no bank changes. Write to back bank while displaying -> led unchanged until next swap.
- POV_STALL_DET_EN with STALL_CYCLES=20: stop fanclk -> stalled=1 and led=0 after 20 cycles; next tick -> stalled=0, led restored.

Source files
------------

// File: rtl/pov_pattern_engine.sv
// rtl/pov_pattern_engine.sv - POV LED fan engine: angle tracking, index sync, double-buffered pattern banks.
// Optional fan stall detection is built when POV_STALL_DET_EN is defined.
module pov_pattern_engine #(
  parameter int LED_W        = 16,
  parameter int STEPS        = 360,
  parameter int ADDR_W       = 9,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fanclk,
  input  logic              index,
  input  logic              dir,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LED_W-1:0]  wr_data,
  input  logic              swap_req,
  input  logic              err_clr,
  output logic [LED_W-1:0]  led,
  output logic [ADDR_W-1:0] angle,
  output logic              rev_tick,
  output logic              swap_pending,
  output logic              sync_err,
  output logic              stalled
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(STEPS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(STEPS);

  if (STALL_CYCLES < 1 || (1 << ADDR_W) < STEPS) begin : g_param_check
    $error("pov_pattern_engine: invalid parameters");
  end

  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect
  logic [2:0] fan_sync;
  logic [2:0] idx_sync;
  logic       step_ev;
  logic       idx_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      fan_sync <= '0;
      idx_sync <= '0;
    end else begin
      fan_sync <= {fan_sync[1:0], fanclk};
      idx_sync <= {idx_sync[1:0], index};
    end
  end

  assign step_ev = fan_sync[1] & ~fan_sync[2];
  assign idx_ev  = idx_sync[1] & ~idx_sync[2];

  logic [ADDR_W-1:0] angle_nxt;
  logic              boundary;
  logic              misalign;

  always_comb begin
    angle_nxt = angle;
    if (idx_ev) begin
      angle_nxt = '0;
    end else if (step_ev) begin
      if (dir) angle_nxt = (angle == LAST) ? '0 : angle + ONE;
      else     angle_nxt = (angle == '0) ? LAST : angle - ONE;
    end
  end

  assign boundary = (angle_nxt == '0) && (angle != '0);
  assign misalign = idx_ev && (angle != '0) && (angle != (dir ? LAST : ONE));

  logic [LED_W-1:0] bank0 [STEPS];
  logic [LED_W-1:0] bank1 [STEPS];
  logic             bank_sel;
  logic             blank;
  logic [LED_W-1:0] front_word;

  // bank_sel names the front bank; the other one is host-writable
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < LIMIT)) begin
      if (bank_sel) bank0[wr_addr] <= wr_data;
      else          bank1[wr_addr] <= wr_data;
    end
  end

  assign front_word = bank_sel ? bank1[angle] : bank0[angle];

  logic stall_now;

`ifdef POV_STALL_DET_EN
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES);
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || step_ev) stall_cnt <= '0;
    else if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign stall_now = (stall_cnt == CNT_MAX);
`else
  assign stall_now = 1'b0;
`endif

  assign stalled = stall_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      angle        <= '0;
      rev_tick     <= 1'b0;
      swap_pending <= 1'b0;
      sync_err     <= 1'b0;
      bank_sel     <= 1'b0;
      blank        <= 1'b1;
      led          <= '0;
    end else begin
      angle    <= angle_nxt;
      rev_tick <= boundary;
      led      <= (blank || stall_now) ? '0 : front_word;

      if (misalign)     sync_err <= 1'b1;
      else if (err_clr) sync_err <= 1'b0;

      // a request landing on the boundary itself waits for the next one
      if (boundary && swap_pending) begin
        bank_sel     <= ~bank_sel;
        blank        <= 1'b0;
        swap_pending <= swap_req;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pov_pattern_engine.sv
// tb/tb_pov_pattern_engine.sv - directed self-checking bench for pov_pattern_engine.
module tb_pov_pattern_engine;

  localparam int LED_W = 16;
  localparam int STEPS = 360;
  localparam int ADDR_W = 9;

  logic              clk;
  logic              rst;
  logic              fanclk;
  logic              index;
  logic              dir;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LED_W-1:0]  wr_data;
  logic              swap_req;
  logic              err_clr;
  logic [LED_W-1:0]  led;
  logic [ADDR_W-1:0] angle;
  logic              rev_tick;
  logic              swap_pending;
  logic              sync_err;
  logic              stalled;

  int vec = 0;
  int err = 0;

  pov_pattern_engine #(
    .LED_W(LED_W), .STEPS(STEPS), .ADDR_W(ADDR_W), .STALL_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .fanclk(fanclk), .index(index), .dir(dir),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .err_clr(err_clr), .led(led), .angle(angle),
    .rev_tick(rev_tick), .swap_pending(swap_pending), .sync_err(sync_err),
    .stalled(stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-cycle input pulses; returns just after the edge where angle updates
  task automatic ev(input logic f, input logic i, input logic s, input logic c);
    fanclk = f; index = i;
    @(posedge clk); #1;
    fanclk = 1'b0; index = 1'b0;
    @(posedge clk); #1;
    swap_req = s; err_clr = c;
    @(posedge clk); #1;
    swap_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) ev(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [LED_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    vec++; if (angle !== 9'd0) begin $display("FAIL reset_angle got %0d want 0", angle); err++; end
    vec++; if (led !== 16'd0) begin $display("FAIL reset_led got %h want 0", led); err++; end
    vec++; if ({rev_tick, swap_pending, sync_err, stalled} !== 4'b0000) begin
      $display("FAIL reset_flags got %b want 0000", {rev_tick, swap_pending, sync_err, stalled}); err++;
    end
  endtask

  task automatic test_dir0;
    logic [ADDR_W-1:0] exp;
    dir = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp = ADDR_W'(STEPS - k);
      ev(1'b1, 1'b0, 1'b0, 1'b0);
      vec++; if (angle !== exp) begin $display("FAIL dir0_angle got %0d want %0d", angle, exp); err++; end
      vec++; if (rev_tick !== 1'b0) begin $display("FAIL dir0_rev got %b want 0", rev_tick); err++; end
      cyc(1);
      vec++; if (led !== 16'd0) begin $display("FAIL dir0_blank got %h want 0", led); err++; end
    end
  endtask

  task automatic test_swap;
    logic [ADDR_W-1:0] exp;
    for (int k = 0; k < STEPS; k++) wr(k, LED_W'(k));
    swap_req = 1'b1; cyc(1); swap_req = 1'b0; cyc(1);
    swap_req = 1'b1; cyc(1); swap_req = 1'b0; cyc(1);
    vec++; if (swap_pending !== 1'b1) begin $display("FAIL swap_armed got %b want 1", swap_pending); err++; end
    dir = 1'b1;
    for (int k = 356; k <= 359; k++) begin
      exp = ADDR_W'(k);
      ev(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1);
      vec++; if (angle !== exp || led !== 16'd0 || swap_pending !== 1'b1) begin
        $display("FAIL swap_prewrap got a=%0d led=%h p=%b want a=%0d led=0 p=1", angle, led, swap_pending, exp); err++;
      end
    end
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    vec++; if (angle !== 9'd0 || rev_tick !== 1'b1 || swap_pending !== 1'b0) begin
      $display("FAIL swap_wrap got a=%0d rt=%b p=%b want a=0 rt=1 p=0", angle, rev_tick, swap_pending); err++;
    end
    cyc(1);
    vec++; if (rev_tick !== 1'b0 || led !== 16'd0) begin
      $display("FAIL swap_after got rt=%b led=%h want rt=0 led=0", rev_tick, led); err++;
    end
    for (int k = 1; k <= 5; k++) begin
      ev(1'b1, 1'b0, 1'b0, 1'b0);
      vec++; if (led !== LED_W'(k - 1)) begin $display("FAIL led_lag got %h want %h", led, LED_W'(k - 1)); err++; end
      cyc(1);
      vec++; if (led !== LED_W'(k)) begin $display("FAIL led_follow got %h want %h", led, LED_W'(k)); err++; end
    end
  endtask

  task automatic test_index;
    dir = 1'b1;
    steps(95);
    vec++; if (angle !== 9'd100) begin $display("FAIL idx_pre got %0d want 100", angle); err++; end
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    vec++; if (angle !== 9'd0 || sync_err !== 1'b1 || rev_tick !== 1'b1) begin
      $display("FAIL idx_misalign got a=%0d e=%b rt=%b want a=0 e=1 rt=1", angle, sync_err, rev_tick); err++;
    end
    cyc(5);
    vec++; if (sync_err !== 1'b1) begin $display("FAIL err_sticky got %b want 1", sync_err); err++; end
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    vec++; if (sync_err !== 1'b0) begin $display("FAIL err_clr got %b want 0", sync_err); err++; end
    dir = 1'b0;
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    dir = 1'b1;
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    vec++; if (angle !== 9'd0 || sync_err !== 1'b0 || rev_tick !== 1'b1) begin
      $display("FAIL idx_at359 got a=%0d e=%b rt=%b want a=0 e=0 rt=1", angle, sync_err, rev_tick); err++;
    end
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    vec++; if (angle !== 9'd0 || sync_err !== 1'b0 || rev_tick !== 1'b0) begin
      $display("FAIL idx_at0 got a=%0d e=%b rt=%b want a=0 e=0 rt=0", angle, sync_err, rev_tick); err++;
    end
  endtask

  task automatic test_both;
    dir = 1'b1;
    steps(50);
    vec++; if (angle !== 9'd50) begin $display("FAIL both_pre got %0d want 50", angle); err++; end
    ev(1'b1, 1'b1, 1'b0, 1'b1);
    vec++; if (angle !== 9'd0 || rev_tick !== 1'b1) begin
      $display("FAIL both_prio got a=%0d rt=%b want a=0 rt=1", angle, rev_tick); err++;
    end
    vec++; if (sync_err !== 1'b1) begin $display("FAIL set_wins got %b want 1", sync_err); err++; end
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
  endtask

  task automatic test_wr;
    wr(400, 16'hFFFF);
    for (int k = 0; k < STEPS; k++) wr(k, LED_W'(k) ^ 16'h5555);
    steps(11);
    cyc(1);
    vec++; if (angle !== 9'd11 || led !== 16'd11) begin
      $display("FAIL back_write got a=%0d led=%h want a=11 led=000b", angle, led); err++;
    end
    swap_req = 1'b1; cyc(1); swap_req = 1'b0;
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    vec++; if (swap_pending !== 1'b0 || angle !== 9'd0) begin
      $display("FAIL idx_swap got p=%b a=%0d want p=0 a=0", swap_pending, angle); err++;
    end
    cyc(1);
    vec++; if (led !== 16'h5555) begin $display("FAIL newbank0 got %h want 5555", led); err++; end
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    vec++; if (led !== 16'h5554) begin $display("FAIL newbank1 got %h want 5554", led); err++; end
  endtask

  task automatic test_back_to_back;
    dir = 1'b0;
    ev(1'b1, 1'b0, 1'b1, 1'b0);
    vec++; if (angle !== 9'd0 || rev_tick !== 1'b1 || swap_pending !== 1'b1) begin
      $display("FAIL coinc_req got a=%0d rt=%b p=%b want a=0 rt=1 p=1", angle, rev_tick, swap_pending); err++;
    end
    cyc(1);
    vec++; if (led !== 16'h5555) begin $display("FAIL coinc_hold got %h want 5555", led); err++; end
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    vec++; if (led !== (16'd359 ^ 16'h5555)) begin $display("FAIL wrap359 got %h want 5432", led); err++; end
    dir = 1'b1;
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    vec++; if (swap_pending !== 1'b0 || sync_err !== 1'b0) begin
      $display("FAIL coinc_take got p=%b e=%b want p=0 e=0", swap_pending, sync_err); err++;
    end
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    vec++; if (led !== 16'd1) begin $display("FAIL swap_back got %h want 0001", led); err++; end
  endtask

`ifdef POV_STALL_DET_EN
  task automatic test_stall;
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(19);
    vec++; if (stalled !== 1'b0) begin $display("FAIL stall_early got %b want 0", stalled); err++; end
    cyc(1);
    vec++; if (stalled !== 1'b1) begin $display("FAIL stall_set got %b want 1", stalled); err++; end
    cyc(1);
    vec++; if (led !== 16'd0 || angle !== 9'd2) begin
      $display("FAIL stall_led got led=%h a=%0d want led=0 a=2", led, angle); err++;
    end
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    vec++; if (stalled !== 1'b0) begin $display("FAIL stall_clr got %b want 0", stalled); err++; end
    cyc(1);
    vec++; if (led !== 16'd3) begin $display("FAIL stall_resume got %h want 0003", led); err++; end
  endtask
`endif

  task automatic test_midreset;
    rst = 1'b1; cyc(1); rst = 1'b0;
    vec++; if (angle !== 9'd0 || led !== 16'd0 || swap_pending !== 1'b0 || sync_err !== 1'b0) begin
      $display("FAIL midrst got a=%0d led=%h p=%b e=%b want all 0", angle, led, swap_pending, sync_err); err++;
    end
    dir = 1'b1;
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    vec++; if (angle !== 9'd1 || led !== 16'd0) begin
      $display("FAIL midrst_blank got a=%0d led=%h want a=1 led=0", angle, led); err++;
    end
  endtask

  initial begin
    rst = 1'b1; fanclk = 1'b0; index = 1'b0; dir = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; swap_req = 1'b0; err_clr = 1'b0;
    test_reset();
    test_dir0();
    test_swap();
    test_index();
    test_both();
    test_wr();
    test_back_to_back();
`ifdef POV_STALL_DET_EN
    test_stall();
`endif
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
